// File: rtl/ethrecv_pkg.sv
// Shared definitions for the GMII receive frame engine: state encoding,
// preamble/SFD bytes, CRC residue and frame length limits.
package ethrecv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_RECV  = 3'd2,
    S_FLUSH = 3'd3,
    S_CHECK = 3'd4,
    S_DROP  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [7:0]  GMII_PRE        = 8'h55;
  localparam logic [7:0]  GMII_SFD        = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE_DEF = 32'hC704DD7B;
  localparam logic [10:0] MIN_FRAME       = 11'd64;
  localparam logic [10:0] MAX_FRAME       = 11'd1518;

endpackage

// File: rtl/ethrecv.sv
// GMII receive frame engine: strips preamble/SFD, packs frame bytes little-endian
// into 32-bit buffer words, drives the shared CRC engine and reports status.
module ethrecv
  import ethrecv_pkg::*;
#(
  parameter logic [10:0] MAXBYTES    = MAX_FRAME,
  parameter logic [10:0] MINBYTES    = MIN_FRAME,
  parameter logic [31:0] CRC_RESIDUE = CRC_RESIDUE_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        rxena,
  output logic        rxdone,
  input  logic        rxdv,
  input  logic        rxer,
  input  logic [7:0]  datain,
  input  logic [31:0] crc,
  output logic [7:0]  crcdat,
  output logic        crcen,
  output logic        crcre,
  output logic [31:0] rxbdata,
  output logic [8:0]  rxbaddr,
  output logic        rxbwe,
  output logic [10:0] rxcntb,
  output logic        crc_err,
  output logic        len_err,
  output logic        rx_err,
  output logic        err_gen
);

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [8:0]  rxbaddr_q, rxbaddr_d;
  logic [31:0] rxbdata_q, rxbdata_d;
  logic        rxbwe_q, rxbwe_d;
  logic [7:0]  crcdat_q, crcdat_d;
  logic        crcen_q, crcen_d;
  logic        crcre_q, crcre_d;
  logic [10:0] rxcntb_q, rxcntb_d;
  logic        rxdone_q, rxdone_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;
  logic        rx_err_q, rx_err_d;

  // Lane 0 starts a fresh word so a trailing partial word has zeroed upper bytes.
  function automatic logic [31:0] pack_byte(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [7:0] b);
    logic [31:0] r;
    r = (lane == 2'd0) ? 32'h0 : w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rxbaddr_d = rxbaddr_q + {8'd0, rxbwe_q};
    rxbdata_d = rxbdata_q;
    rxbwe_d   = 1'b0;
    crcdat_d  = crcdat_q;
    crcen_d   = 1'b0;
    crcre_d   = crcre_q;
    rxcntb_d  = rxcntb_q;
    rxdone_d  = rxdone_q;
    crc_err_d = crc_err_q;
    len_err_d = len_err_q;
    rx_err_d  = rx_err_q;
    unique case (state_q)
      S_IDLE: begin
        crcre_d   = 1'b1;
        rxbaddr_d = 9'd0;
        cnt_d     = 11'd0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;
        rx_err_d  = 1'b0;
        rxdone_d  = 1'b0;
        if (rxena && rxdv) state_d = (datain == GMII_PRE) ? S_PRE : S_DROP;
      end
      S_PRE: begin
        if (!rxdv)                  state_d = S_IDLE;
        else if (datain == GMII_SFD) begin
          state_d = S_RECV;
          crcre_d = 1'b0;
        end else if (datain != GMII_PRE) state_d = S_DROP;
      end
      S_RECV: begin
        if (!rxdv) begin
          state_d = S_FLUSH;
        end else if (cnt_q == MAXBYTES) begin
          len_err_d = 1'b1;
          state_d   = S_DROP;
        end else begin
          crcdat_d  = datain;
          crcen_d   = 1'b1;
          cnt_d     = cnt_q + 11'd1;
          rxbdata_d = pack_byte(rxbdata_q, cnt_q[1:0], datain);
          rxbwe_d   = (cnt_q[1:0] == 2'd3);
          if (rxer) rx_err_d = 1'b1;
        end
      end
      S_FLUSH: begin
        rxbwe_d = (cnt_q[1:0] != 2'd0);
        state_d = S_CHECK;
      end
      S_CHECK: begin
        crc_err_d = (crc != CRC_RESIDUE);
        len_err_d = len_err_q | (cnt_q < MINBYTES);
        rxcntb_d  = cnt_q;
        rxdone_d  = 1'b1;
        state_d   = S_DONE;
      end
      S_DROP: begin
        if (!rxdv) state_d = len_err_q ? S_CHECK : S_IDLE;
      end
      S_DONE: begin
        if (!rxena) begin
          rxdone_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= 11'd0;
      rxbaddr_q <= 9'd0;
      rxbdata_q <= 32'h0;
      rxbwe_q   <= 1'b0;
      crcdat_q  <= 8'h0;
      crcen_q   <= 1'b0;
      crcre_q   <= 1'b1;
      rxcntb_q  <= 11'd0;
      rxdone_q  <= 1'b0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      rx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rxbaddr_q <= rxbaddr_d;
      rxbdata_q <= rxbdata_d;
      rxbwe_q   <= rxbwe_d;
      crcdat_q  <= crcdat_d;
      crcen_q   <= crcen_d;
      crcre_q   <= crcre_d;
      rxcntb_q  <= rxcntb_d;
      rxdone_q  <= rxdone_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      rx_err_q  <= rx_err_d;
    end
  end

  assign rxdone  = rxdone_q;
  assign crcdat  = crcdat_q;
  assign crcen   = crcen_q;
  assign crcre   = crcre_q;
  assign rxbdata = rxbdata_q;
  assign rxbaddr = rxbaddr_q;
  assign rxbwe   = rxbwe_q;
  assign rxcntb  = rxcntb_q;
  assign crc_err = crc_err_q;
  assign len_err = len_err_q;
  assign rx_err  = rx_err_q;
  assign err_gen = crc_err_q | len_err_q | rx_err_q;

endmodule

// File: tb/tb_ethrecv.sv
// Directed/randomized bench for ethrecv with a behavioural CRC engine and
// a frame-level reference model (expected words, count and flags from the byte list).
module tb_ethrecv;
  localparam int MAXB = 1518;
  localparam int MINB = 64;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        rxena = 1'b0;
  logic        rxdv = 1'b0;
  logic        rxer = 1'b0;
  logic [7:0]  datain = 8'h00;
  logic [31:0] crc;
  logic        rxdone, crcen, crcre, rxbwe, crc_err, len_err, rx_err, err_gen;
  logic [7:0]  crcdat;
  logic [31:0] rxbdata;
  logic [8:0]  rxbaddr;
  logic [10:0] rxcntb;

  int checks = 0;
  int errors = 0;
  logic [7:0]  frame[$];
  logic [8:0]  waddr[$];
  logic [31:0] wdata[$];
  logic [31:0] crc_reg;

  ethrecv dut (
    .clk(clk), .clr(clr), .rxena(rxena), .rxdone(rxdone), .rxdv(rxdv), .rxer(rxer),
    .datain(datain), .crc(crc), .crcdat(crcdat), .crcen(crcen), .crcre(crcre),
    .rxbdata(rxbdata), .rxbaddr(rxbaddr), .rxbwe(rxbwe), .rxcntb(rxcntb),
    .crc_err(crc_err), .len_err(len_err), .rx_err(rx_err), .err_gen(err_gen)
  );

  always #4 clk = ~clk;

  function automatic logic [31:0] crc_upd(input logic [31:0] r, input logic [7:0] d);
    logic [31:0] x;
    x = r;
    for (int i = 0; i < 8; i++) x = (x >> 1) ^ ((x[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return x;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // External byte-serial CRC engine; its register is reported bit-reversed.
  always @(posedge clk or posedge clr) begin
    if (clr)        crc_reg <= 32'hFFFFFFFF;
    else if (crcre) crc_reg <= 32'hFFFFFFFF;
    else if (crcen) crc_reg <= crc_upd(crc_reg, crcdat);
  end
  assign crc = bitrev(crc_reg);

  always @(negedge clk) begin
    if (rxbwe === 1'b1) begin
      waddr.push_back(rxbaddr);
      wdata.push_back(rxbdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build(input int n, input bit seq);
    logic [31:0] r;
    frame.delete();
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n - 4; i++) begin
      frame.push_back(seq ? 8'(i) : 8'($urandom_range(0, 255)));
      r = crc_upd(r, frame[i]);
    end
    r = ~r;
    for (int j = 0; j < 4; j++) frame.push_back(r[8*j +: 8]);
  endtask

  task automatic drive(input logic [7:0] b);
    rxdv = 1'b1;
    datain = b;
    @(negedge clk);
  endtask

  task automatic send(input int rxer_at, output int lat);
    waddr.delete();
    wdata.delete();
    for (int i = 0; i < 7; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < frame.size(); i++) begin
      rxer = (i == rxer_at);
      drive(frame[i]);
    end
    rxdv = 1'b0;
    rxer = 1'b0;
    datain = 8'h00;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (rxdone === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic verify(input string tag, input int exp_crc, input bit exp_rxe,
                        input int lat, input int exp_lat);
    int len, n, nw;
    bit lerr;
    logic [31:0] ew;
    len = frame.size();
    n = (len > MAXB) ? MAXB : len;
    nw = (len > MAXB) ? MAXB / 4 : (n + 3) / 4;
    lerr = (len < MINB) || (len > MAXB);
    if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
    else             check({tag, " rxdone seen"}, 32'(lat != 0), 1);
    check({tag, " writes"}, waddr.size(), nw);
    for (int w = 0; w < nw && w < waddr.size(); w++) begin
      for (int j = 0; j < 4; j++) ew[8*j +: 8] = (4*w + j < n) ? frame[4*w + j] : 8'h00;
      check({tag, " addr"}, waddr[w], w);
      check({tag, " word"}, wdata[w], ew);
    end
    check({tag, " rxcntb"}, rxcntb, n);
    check({tag, " len_err"}, len_err, lerr);
    if (exp_crc >= 0) check({tag, " crc_err"}, crc_err, exp_crc);
    check({tag, " rx_err"}, rx_err, exp_rxe);
    check({tag, " err_gen"}, err_gen, lerr | (exp_crc == 1) | exp_rxe);
    rxena = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, " rxdone released"}, rxdone, 0);
    rxena = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rxdone"}, rxdone, 0);
    check({tag, " crcen"}, crcen, 0);
    check({tag, " crcre"}, crcre, 1);
    check({tag, " rxbwe"}, rxbwe, 0);
    check({tag, " rxbaddr"}, rxbaddr, 0);
    check({tag, " rxcntb"}, rxcntb, 0);
    check({tag, " rxbdata"}, rxbdata, 0);
    check({tag, " crcdat"}, crcdat, 0);
    check({tag, " flags"}, {crc_err, len_err, rx_err, err_gen}, 0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    check_reset("reset");
    clr = 1'b0;
    rxena = 1'b1;
    repeat (2) @(negedge clk);

    build(64, 1'b1);
    send(-1, lat);
    check("t1 word0", (wdata.size() > 0) ? wdata[0] : 32'hX, 32'h03020100);
    verify("t1 good64", 0, 1'b0, lat, 3);

    build(64, 1'b1);
    frame[10] = ~frame[10];
    send(-1, lat);
    verify("t2 badfcs", 1, 1'b0, lat, 3);

    build(67, 1'b0);
    send(-1, lat);
    verify("t3 len67", 0, 1'b0, lat, 3);

    build(40, 1'b0);
    send(-1, lat);
    verify("t4 runt", 0, 1'b0, lat, 3);

    build(1600, 1'b0);
    send(-1, lat);
    verify("t4 long", -1, 1'b0, lat, 0);

    build(100, 1'b0);
    send(37, lat);
    verify("t5 rxer", 0, 1'b1, lat, 3);

    rxena = 1'b0;
    build(64, 1'b0);
    send(-1, lat);
    check("t5 disabled rxdone", 32'(lat), 0);
    check("t5 disabled writes", waddr.size(), 0);
    rxena = 1'b1;
    repeat (2) @(negedge clk);

    build(80, 1'b0);
    for (int i = 0; i < 7; i++) drive(8'h55);
    drive(8'hD5);
    for (int i = 0; i < 30; i++) drive(frame[i]);
    clr = 1'b1;
    #1;
    check_reset("t6 clr");
    @(negedge clk);
    clr = 1'b0;
    rxdv = 1'b0;
    repeat (3) @(negedge clk);
    build(72, 1'b0);
    send(-1, lat);
    verify("t6 after clr", 0, 1'b0, lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
